// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS core: sequences IF/ID/EXE/MEM/WB/MDW
// and drives every datapath enable and mux select from (state, instr).
module mc_ctrl #(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        md_busy,
  output logic [2:0]  state,
  output logic        pc_w,
  output logic [1:0]  pc_sel,
  output logic        ir_w,
  output logic        z_w,
  output logic        z_oe,
  output logic [3:0]  aluc,
  output logic [1:0]  a_sel,
  output logic [1:0]  b_sel,
  output logic        rf_w,
  output logic [1:0]  rf_wa_sel,
  output logic [1:0]  rf_wd_sel,
  output logic        dmem_r,
  output logic        dmem_w,
  output logic        md_start,
  output logic        illegal
);

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EXE = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;
  localparam logic [2:0] S_MDW = 3'd5;

  logic [2:0] state_q, state_d;
  logic [5:0] op, fn;
  logic r_alu, r_sh, r_shv, i_alu, md;
  logic lw, sw, beq, bne, j, jal, jr, legal;
  logic [3:0] alu_op;
  logic unused_ok;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign unused_ok = ^instr[25:6];

  always_comb begin
    r_alu = 1'b0; r_sh = 1'b0; r_shv = 1'b0;
    i_alu = 1'b0; md = 1'b0; jr = 1'b0;
    lw = 1'b0; sw = 1'b0; beq = 1'b0;
    bne = 1'b0; j = 1'b0; jal = 1'b0;
    alu_op = 4'b0000;
    if (op == 6'h00) begin
      case (fn)
        6'h20: begin r_alu = 1'b1; alu_op = 4'b0010; end
        6'h21: begin r_alu = 1'b1; alu_op = 4'b0000; end
        6'h22: begin r_alu = 1'b1; alu_op = 4'b0011; end
        6'h23: begin r_alu = 1'b1; alu_op = 4'b0001; end
        6'h24: begin r_alu = 1'b1; alu_op = 4'b0100; end
        6'h25: begin r_alu = 1'b1; alu_op = 4'b0101; end
        6'h26: begin r_alu = 1'b1; alu_op = 4'b0110; end
        6'h27: begin r_alu = 1'b1; alu_op = 4'b0111; end
        6'h2A: begin r_alu = 1'b1; alu_op = 4'b1011; end
        6'h2B: begin r_alu = 1'b1; alu_op = 4'b1010; end
        6'h00: begin r_sh = 1'b1; alu_op = 4'b1110; end
        6'h02: begin r_sh = 1'b1; alu_op = 4'b1101; end
        6'h03: begin r_sh = 1'b1; alu_op = 4'b1100; end
        6'h04: begin r_shv = 1'b1; alu_op = 4'b1110; end
        6'h06: begin r_shv = 1'b1; alu_op = 4'b1101; end
        6'h07: begin r_shv = 1'b1; alu_op = 4'b1100; end
        6'h08: jr = 1'b1;
        6'h18, 6'h19, 6'h1A, 6'h1B: md = 1'b1;
        default: ;
      endcase
    end else begin
      case (op)
        6'h08: begin i_alu = 1'b1; alu_op = 4'b0010; end
        6'h09: begin i_alu = 1'b1; alu_op = 4'b0000; end
        6'h0A: begin i_alu = 1'b1; alu_op = 4'b1011; end
        6'h0B: begin i_alu = 1'b1; alu_op = 4'b1010; end
        6'h0C: begin i_alu = 1'b1; alu_op = 4'b0100; end
        6'h0D: begin i_alu = 1'b1; alu_op = 4'b0101; end
        6'h0E: begin i_alu = 1'b1; alu_op = 4'b0110; end
        6'h0F: begin i_alu = 1'b1; alu_op = 4'b1000; end
        6'h23: begin lw = 1'b1; alu_op = 4'b0010; end
        6'h2B: begin sw = 1'b1; alu_op = 4'b0010; end
        6'h04: begin beq = 1'b1; alu_op = 4'b0001; end
        6'h05: begin bne = 1'b1; alu_op = 4'b0001; end
        6'h02: j = 1'b1;
        6'h03: jal = 1'b1;
        default: ;
      endcase
    end
  end

  assign legal = r_alu | r_sh | r_shv | i_alu | md | jr |
                 lw | sw | beq | bne | j | jal;

  always_ff @(posedge clk) begin
    if (rst) state_q <= RESET_STATE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:  state_d = S_ID;
      S_ID: begin
        if (j | jr | ~legal) state_d = S_IF;
        else if (jal)        state_d = S_WB;
        else                 state_d = S_EXE;
      end
      S_EXE: begin
        if (lw | sw)        state_d = S_MEM;
        else if (beq | bne) state_d = S_IF;
        else if (md)        state_d = S_MDW;
        else                state_d = S_WB;
      end
      S_MEM: state_d = lw ? S_WB : S_IF;
      S_WB:  state_d = S_IF;
      S_MDW: state_d = md_busy ? S_MDW : S_IF;
      default: state_d = S_IF;
    endcase
  end

  // Enables are masked by rst so a reset aborts any in-flight write.
  always_comb begin
    pc_w = 1'b0; pc_sel = 2'd0; ir_w = 1'b0;
    z_w = 1'b0; z_oe = 1'b0; aluc = 4'b0000;
    a_sel = 2'd0; b_sel = 2'd0; rf_w = 1'b0;
    rf_wa_sel = 2'd0; rf_wd_sel = 2'd0;
    dmem_r = 1'b0; dmem_w = 1'b0;
    md_start = 1'b0; illegal = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IF: begin
          ir_w = 1'b1;
          pc_w = 1'b1;
        end
        S_ID: begin
          if (j) begin
            pc_sel = 2'd2; pc_w = 1'b1;
          end else if (jr) begin
            pc_sel = 2'd3; pc_w = 1'b1;
          end else if (!legal) begin
            illegal = 1'b1;
          end
        end
        S_EXE: begin
          aluc = alu_op;
          unique case (1'b1)
            r_alu: begin a_sel = 2'd1; b_sel = 2'd1; z_w = 1'b1; end
            r_sh:  begin a_sel = 2'd2; b_sel = 2'd1; z_w = 1'b1; end
            r_shv: begin a_sel = 2'd1; b_sel = 2'd1; z_w = 1'b1; end
            i_alu: begin
              a_sel = 2'd1;
              b_sel = op[2] ? 2'd3 : 2'd2;
              z_w = 1'b1;
            end
            lw, sw: begin a_sel = 2'd1; b_sel = 2'd2; z_w = 1'b1; end
            beq, bne: begin
              a_sel = 2'd1; b_sel = 2'd1;
              if ((beq & zero) | (bne & ~zero)) begin
                pc_sel = 2'd1; pc_w = 1'b1;
              end
            end
            md: md_start = 1'b1;
            default: ;
          endcase
        end
        S_MEM: begin
          z_oe = 1'b1;
          dmem_r = lw;
          dmem_w = sw & ~lw;
        end
        S_WB: begin
          rf_w = 1'b1;
          if (jal) begin
            rf_wa_sel = 2'd2; rf_wd_sel = 2'd2;
            pc_sel = 2'd2; pc_w = 1'b1;
          end else if (lw) begin
            rf_wa_sel = 2'd1; rf_wd_sel = 2'd1;
          end else if (i_alu) begin
            rf_wa_sel = 2'd1; z_oe = 1'b1;
          end else begin
            z_oe = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed table-driven bench for mc_ctrl: one record per clock cycle,
// plus hand-written mult/div handshake sequences.
module tb_mc_ctrl;

  logic clk = 1'b0;
  logic rst, zero, md_busy;
  logic [31:0] instr;
  logic [2:0] state;
  logic pc_w, ir_w, z_w, z_oe, rf_w;
  logic dmem_r, dmem_w, md_start, illegal;
  logic [1:0] pc_sel, a_sel, b_sel, rf_wa_sel, rf_wd_sel;
  logic [3:0] aluc;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero),
    .md_busy(md_busy), .state(state), .pc_w(pc_w),
    .pc_sel(pc_sel), .ir_w(ir_w), .z_w(z_w), .z_oe(z_oe),
    .aluc(aluc), .a_sel(a_sel), .b_sel(b_sel), .rf_w(rf_w),
    .rf_wa_sel(rf_wa_sel), .rf_wd_sel(rf_wd_sel),
    .dmem_r(dmem_r), .dmem_w(dmem_w),
    .md_start(md_start), .illegal(illegal)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       pc_w;
    logic [1:0] pc_sel;
    logic       ir_w;
    logic       z_w;
    logic       z_oe;
    logic [3:0] aluc;
    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic       rf_w;
    logic [1:0] wa;
    logic [1:0] wd;
    logic       dr;
    logic       dw;
    logic       ms;
    logic       ill;
  } out_t;

  typedef struct {
    string       nm;
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic        busy;
    out_t        e;
  } vec_t;

  localparam logic [31:0] I_ADDU  = 32'h00221821;
  localparam logic [31:0] I_LW    = 32'h8C850008;
  localparam logic [31:0] I_BEQ   = 32'h10220003;
  localparam logic [31:0] I_JAL   = 32'h0C000010;
  localparam logic [31:0] I_J     = 32'h08000010;
  localparam logic [31:0] I_JR    = 32'h03E00008;
  localparam logic [31:0] I_ANDI  = 32'h308300FF;
  localparam logic [31:0] I_SLL   = 32'h00041080;
  localparam logic [31:0] I_SRAV  = 32'h00A41007;
  localparam logic [31:0] I_SLTI  = 32'h2883FFFF;
  localparam logic [31:0] I_SW    = 32'hAC850008;
  localparam logic [31:0] I_ILL   = 32'hFC000000;
  localparam logic [31:0] I_DIV   = 32'h0022001A;
  localparam logic [31:0] I_MULTU = 32'h00220019;

  out_t act;
  assign act = {state, pc_w, pc_sel, ir_w, z_w, z_oe, aluc,
                a_sel, b_sel, rf_w, rf_wa_sel, rf_wd_sel,
                dmem_r, dmem_w, md_start, illegal};

  vec_t tv[$];
  int total = 0;
  int passed = 0;

  out_t O_IF, O_ID, O_RST;

  function automatic void add(string nm, logic r, logic [31:0] ins,
                              logic z, logic b, out_t e);
    vec_t v;
    v.nm = nm; v.rst = r; v.instr = ins;
    v.zero = z; v.busy = b; v.e = e;
    tv.push_back(v);
  endfunction

  task automatic chk(string nm, out_t e);
    total++;
    if (act !== e)
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, e, $time);
    else
      passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    O_IF  = '{st:3'd0, pc_w:1'b1, ir_w:1'b1, default:0};
    O_ID  = '{st:3'd1, default:0};
    O_RST = '{st:3'd0, default:0};

    add("rst0", 1, I_ADDU, 0, 0, O_RST);
    add("rst1", 1, I_ADDU, 0, 0, O_RST);
    add("addu_if", 0, I_ADDU, 0, 0, O_IF);
    add("addu_id", 0, I_ADDU, 0, 0, O_ID);
    add("addu_exe", 0, I_ADDU, 0, 0,
        '{st:3'd2, z_w:1'b1, aluc:4'b0000, a_sel:2'd1, b_sel:2'd1, default:0});
    add("addu_wb", 0, I_ADDU, 0, 0,
        '{st:3'd4, rf_w:1'b1, z_oe:1'b1, default:0});

    add("lw_if", 0, I_LW, 0, 0, O_IF);
    add("lw_id", 0, I_LW, 0, 0, O_ID);
    add("lw_exe", 0, I_LW, 0, 0,
        '{st:3'd2, z_w:1'b1, aluc:4'b0010, a_sel:2'd1, b_sel:2'd2, default:0});
    add("lw_mem", 0, I_LW, 0, 0,
        '{st:3'd3, z_oe:1'b1, dr:1'b1, default:0});
    add("lw_wb", 0, I_LW, 0, 0,
        '{st:3'd4, rf_w:1'b1, wa:2'd1, wd:2'd1, default:0});

    add("beqt_if", 0, I_BEQ, 1, 0, O_IF);
    add("beqt_id", 0, I_BEQ, 1, 0, O_ID);
    add("beqt_exe", 0, I_BEQ, 1, 0,
        '{st:3'd2, aluc:4'b0001, a_sel:2'd1, b_sel:2'd1,
          pc_sel:2'd1, pc_w:1'b1, default:0});
    add("beqn_if", 0, I_BEQ, 0, 0, O_IF);
    add("beqn_id", 0, I_BEQ, 0, 0, O_ID);
    add("beqn_exe", 0, I_BEQ, 0, 0,
        '{st:3'd2, aluc:4'b0001, a_sel:2'd1, b_sel:2'd1, default:0});

    add("jal_if", 0, I_JAL, 0, 0, O_IF);
    add("jal_id", 0, I_JAL, 0, 0, O_ID);
    add("jal_wb", 0, I_JAL, 0, 0,
        '{st:3'd4, rf_w:1'b1, wa:2'd2, wd:2'd2,
          pc_sel:2'd2, pc_w:1'b1, default:0});

    add("j_if", 0, I_J, 0, 0, O_IF);
    add("j_id", 0, I_J, 0, 0,
        '{st:3'd1, pc_sel:2'd2, pc_w:1'b1, default:0});
    add("jr_if", 0, I_JR, 0, 0, O_IF);
    add("jr_id", 0, I_JR, 0, 0,
        '{st:3'd1, pc_sel:2'd3, pc_w:1'b1, default:0});

    add("andi_if", 0, I_ANDI, 0, 0, O_IF);
    add("andi_id", 0, I_ANDI, 0, 0, O_ID);
    add("andi_exe", 0, I_ANDI, 0, 0,
        '{st:3'd2, z_w:1'b1, aluc:4'b0100, a_sel:2'd1, b_sel:2'd3, default:0});
    add("andi_wb", 0, I_ANDI, 0, 0,
        '{st:3'd4, rf_w:1'b1, wa:2'd1, z_oe:1'b1, default:0});

    add("sll_if", 0, I_SLL, 0, 0, O_IF);
    add("sll_id", 0, I_SLL, 0, 0, O_ID);
    add("sll_exe", 0, I_SLL, 0, 0,
        '{st:3'd2, z_w:1'b1, aluc:4'b1110, a_sel:2'd2, b_sel:2'd1, default:0});
    add("sll_wb", 0, I_SLL, 0, 0,
        '{st:3'd4, rf_w:1'b1, z_oe:1'b1, default:0});

    add("srav_if", 0, I_SRAV, 0, 0, O_IF);
    add("srav_id", 0, I_SRAV, 0, 0, O_ID);
    add("srav_exe", 0, I_SRAV, 0, 0,
        '{st:3'd2, z_w:1'b1, aluc:4'b1100, a_sel:2'd1, b_sel:2'd1, default:0});
    add("srav_wb", 0, I_SRAV, 0, 0,
        '{st:3'd4, rf_w:1'b1, z_oe:1'b1, default:0});

    add("slti_if", 0, I_SLTI, 0, 0, O_IF);
    add("slti_id", 0, I_SLTI, 0, 0, O_ID);
    add("slti_exe", 0, I_SLTI, 0, 0,
        '{st:3'd2, z_w:1'b1, aluc:4'b1011, a_sel:2'd1, b_sel:2'd2, default:0});
    add("slti_wb", 0, I_SLTI, 0, 0,
        '{st:3'd4, rf_w:1'b1, wa:2'd1, z_oe:1'b1, default:0});

    add("sw_if", 0, I_SW, 0, 0, O_IF);
    add("sw_id", 0, I_SW, 0, 0, O_ID);
    add("sw_exe", 0, I_SW, 0, 0,
        '{st:3'd2, z_w:1'b1, aluc:4'b0010, a_sel:2'd1, b_sel:2'd2, default:0});
    add("sw_mem", 0, I_SW, 0, 0,
        '{st:3'd3, z_oe:1'b1, dw:1'b1, default:0});

    add("swr_if", 0, I_SW, 0, 0, O_IF);
    add("swr_id", 0, I_SW, 0, 0, O_ID);
    add("swr_exe", 0, I_SW, 0, 0,
        '{st:3'd2, z_w:1'b1, aluc:4'b0010, a_sel:2'd1, b_sel:2'd2, default:0});
    add("swr_mem_rst", 1, I_SW, 0, 0, '{st:3'd3, default:0});
    add("swr_after", 0, I_SW, 0, 0, O_IF);
    add("swr_id2", 0, I_SW, 0, 0, O_ID);
    add("swr_exe2", 0, I_SW, 0, 0,
        '{st:3'd2, z_w:1'b1, aluc:4'b0010, a_sel:2'd1, b_sel:2'd2, default:0});
    add("swr_mem2", 0, I_SW, 0, 0,
        '{st:3'd3, z_oe:1'b1, dw:1'b1, default:0});

    add("ill_if", 0, I_ILL, 0, 0, O_IF);
    add("ill_id", 0, I_ILL, 0, 0, '{st:3'd1, ill:1'b1, default:0});

    rst = 1'b1; instr = I_ADDU; zero = 1'b0; md_busy = 1'b0;
    tick();

    foreach (tv[i]) begin
      rst = tv[i].rst;
      instr = tv[i].instr;
      zero = tv[i].zero;
      md_busy = tv[i].busy;
      #4;
      chk(tv[i].nm, tv[i].e);
      tick();
    end

    // DIV: busy high for 5 MDW cycles, then low; IF follows the low cycle.
    rst = 1'b0; instr = I_DIV; zero = 1'b0; md_busy = 1'b0;
    #4; chk("ill_back_if", O_IF); tick();
    #4; chk("div_id", O_ID); tick();
    #4; chk("div_exe", '{st:3'd2, ms:1'b1, default:0}); tick();
    md_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #4; chk($sformatf("div_mdw%0d", k), '{st:3'd5, default:0});
      tick();
    end
    md_busy = 1'b0;
    #4; chk("div_mdw_fall", '{st:3'd5, default:0}); tick();
    instr = I_MULTU;
    #4; chk("div_done_if", O_IF); tick();

    // MULTU with busy already low: single MDW cycle.
    #4; chk("mu_id", O_ID); tick();
    #4; chk("mu_exe", '{st:3'd2, ms:1'b1, default:0}); tick();
    #4; chk("mu_mdw", '{st:3'd5, default:0}); tick();
    #4; chk("mu_if", O_IF); tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
